// File: rtl/rom_load_arbiter_if.sv
// Signal bundle between hps_io download port, the game core read port and the ROM RAM.
// core_rd_req is held with a stable core_rd_addr until core_rd_ack; ack is a one-cycle pulse and core_rd_data stays valid until the next ack.
interface rom_load_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              dn_download;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [DATA_W-1:0] dn_data;
  logic              core_rd_req;
  logic [ADDR_W-1:0] core_rd_addr;
  logic              core_rd_ack;
  logic [DATA_W-1:0] core_rd_data;
  logic              core_reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              dn_err;
  logic [15:0]       dn_checksum;
  logic [1:0]        state_dbg;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data, core_rd_req, core_rd_addr, mem_rdata,
    input  core_rd_ack, core_rd_data, core_reset, mem_addr, mem_we, mem_wdata,
           dn_err, dn_checksum, state_dbg
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data, core_rd_req, core_rd_addr, mem_rdata,
    output core_rd_ack, core_rd_data, core_reset, mem_addr, mem_we, mem_wdata,
           dn_err, dn_checksum, state_dbg
  );
endinterface

// File: rtl/rom_load_arbiter.sv
// ROM RAM owner: sequences ioctl download writes, holds the core in reset, then serves core reads.
// Optional running byte checksum of accepted writes is built when ROM_LOAD_CHECKSUM_EN is defined.
module rom_load_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ROM_SIZE    = 49152,
  parameter int HOLD_CYCLES = 16
) (
  input logic               clk_sys,
  input logic               reset_n,
  rom_load_arbiter_if.slave bus
);
  localparam int                CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W:0]   ROM_LIMIT = (ADDR_W + 1)'(ROM_SIZE);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_pend;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        rd_stage;
  logic [ADDR_W-1:0] rd_addr;
  logic              load_entry;
  logic              wr_hit;
  logic              wr_in_range;

  assign load_entry    = bus.dn_download && (state != ST_LOAD);
  assign wr_hit        = (state == ST_LOAD) && bus.dn_wr;
  assign wr_in_range   = ({1'b0, bus.dn_addr} < ROM_LIMIT);
  assign bus.state_dbg = state;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_HOLD;
      cnt              <= HOLD_INIT;
      bus.core_reset   <= 1'b1;
      bus.mem_we       <= 1'b0;
      bus.mem_addr     <= '0;
      bus.mem_wdata    <= '0;
      bus.core_rd_ack  <= 1'b0;
      bus.core_rd_data <= '0;
      bus.dn_err       <= 1'b0;
      wr_pend          <= 1'b0;
      wr_addr          <= '0;
      wr_data          <= '0;
      rd_stage         <= 2'd0;
      rd_addr          <= '0;
    end else begin
      bus.mem_we      <= 1'b0;
      bus.core_rd_ack <= 1'b0;
      wr_pend         <= 1'b0;

      // A download request overrides everything, including a read in flight.
      if (bus.dn_download) begin
        state          <= ST_LOAD;
        bus.core_reset <= 1'b1;
      end else begin
        case (state)
          ST_LOAD: begin
            state <= ST_HOLD;
            cnt   <= HOLD_INIT;
          end
          ST_HOLD: begin
            if (cnt == '0) begin
              state          <= ST_RUN;
              bus.core_reset <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_RUN:  state <= ST_RUN;
          default: state <= ST_HOLD;
        endcase
      end

      if (load_entry) begin
        bus.dn_err <= 1'b0;
      end else if (wr_hit && !wr_in_range) begin
        bus.dn_err <= 1'b1;
      end

      if (wr_hit && wr_in_range) begin
        wr_pend <= 1'b1;
        wr_addr <= bus.dn_addr;
        wr_data <= bus.dn_data;
      end
      if (wr_pend) begin
        bus.mem_we    <= 1'b1;
        bus.mem_addr  <= wr_addr;
        bus.mem_wdata <= wr_data;
      end

      // Read pipe: accept, drive address, RAM latency, capture and ack.
      if (bus.dn_download) begin
        rd_stage <= 2'd0;
      end else begin
        case (rd_stage)
          2'd0: begin
            if ((state == ST_RUN) && bus.core_rd_req) begin
              rd_stage <= 2'd1;
              rd_addr  <= bus.core_rd_addr;
            end
          end
          2'd1: begin
            bus.mem_addr <= rd_addr;
            rd_stage     <= 2'd2;
          end
          2'd2: rd_stage <= 2'd3;
          default: begin
            bus.core_rd_data <= bus.mem_rdata;
            bus.core_rd_ack  <= 1'b1;
            rd_stage         <= 2'd0;
          end
        endcase
      end
    end
  end

`ifdef ROM_LOAD_CHECKSUM_EN
  logic [15:0] checksum;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 16'h0000;
    end else if (load_entry) begin
      checksum <= 16'h0000;
    end else if (wr_pend) begin
      checksum <= checksum + 16'(wr_data);
    end
  end

  assign bus.dn_checksum = checksum;
`else
  assign bus.dn_checksum = 16'h0000;
`endif
endmodule

// File: tb/tb_rom_load_arbiter.sv
// Bench for rom_load_arbiter: directed scenarios with literal expectations plus randomized
// download/read traffic compared every cycle against a quiet-time / latency reference model.
module tb_rom_load_arbiter;
  localparam int ADDR_W      = 16;
  localparam int DATA_W      = 8;
  localparam int ROM_SIZE    = 49152;
  localparam int HOLD_CYCLES = 16;

  logic clk;
  logic reset_n;
  logic chk_en;
  int   total = 0;
  int   bad   = 0;
  int   we_count = 0;

  rom_load_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rom_load_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_SIZE(ROM_SIZE), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM environment: synchronous read, one cycle after mem_addr.
  logic [7:0] ram    [0:65535];
  bit         ram_wr [0:65535];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[bus.mem_addr]    <= bus.mem_wdata;
      ram_wr[bus.mem_addr] <= 1'b1;
    end
    bus.mem_rdata <= ram_wr[bus.mem_addr] ? ram[bus.mem_addr] : init_val(bus.mem_addr);
  end

  // Reference model. q counts edges since download last seen high; the core runs once
  // q exceeds HOLD_CYCLES (reset counts as one quiet edge). q==0 means loading.
  int          q;
  int          cyc;
  bit          pre_load, pre_run, entry;
  bit          m_we, m_ack, m_err;
  logic [15:0] m_addr, m_sum;
  logic [7:0]  m_wdata, m_rdata;
  bit          acc;
  logic [15:0] acc_a;
  logic [7:0]  acc_d;
  bit          rd_pend;
  int          rd_cyc;
  logic [15:0] rd_a;
  logic [7:0]  ref_mem [0:65535];
  bit          ref_wr  [0:65535];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q = 1; m_we = 0; m_ack = 0; m_err = 0; m_addr = 0; m_sum = 0;
      m_wdata = 0; m_rdata = 0; acc = 0; rd_pend = 0;
    end else begin
      cyc++;
      pre_load = (q == 0);
      pre_run  = (q > HOLD_CYCLES);
      entry    = bus.dn_download && !pre_load;
      if (m_we) begin
        ref_mem[m_addr] = m_wdata;
        ref_wr[m_addr]  = 1'b1;
      end
      m_we  = 0;
      m_ack = 0;
      if (acc) begin
        m_we = 1; m_addr = acc_a; m_wdata = acc_d;
`ifdef ROM_LOAD_CHECKSUM_EN
        m_sum = m_sum + 16'(acc_d);
`endif
      end
      acc = 0;
      if (entry) begin
        m_err = 0;
        m_sum = 0;
      end
      if (pre_load && bus.dn_wr) begin
        if (int'(bus.dn_addr) < ROM_SIZE) begin
          acc = 1; acc_a = bus.dn_addr; acc_d = bus.dn_data;
        end else begin
          m_err = 1;
        end
      end
      if (bus.dn_download) begin
        rd_pend = 0;
      end else if (rd_pend) begin
        if (cyc == rd_cyc + 1) m_addr = rd_a;
        if (cyc == rd_cyc + 3) begin
          m_ack   = 1;
          m_rdata = ref_wr[rd_a] ? ref_mem[rd_a] : init_val(rd_a);
          rd_pend = 0;
        end
      end else if (pre_run && bus.core_rd_req) begin
        rd_pend = 1; rd_cyc = cyc; rd_a = bus.core_rd_addr;
      end
      if (bus.dn_download) q = 0;
      else if (q <= HOLD_CYCLES) q = q + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("core_reset", 32'(bus.core_reset), 32'(q <= HOLD_CYCLES));
      chk("mem_we", 32'(bus.mem_we), 32'(m_we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
      chk("rd_ack", 32'(bus.core_rd_ack), 32'(m_ack));
      chk("rd_data", 32'(bus.core_rd_data), 32'(m_rdata));
      chk("dn_err", 32'(bus.dn_err), 32'(m_err));
      chk("dn_checksum", 32'(bus.dn_checksum), 32'(m_sum));
      if (bus.mem_we) we_count++;
    end
  end

  task automatic wr_byte(input logic [15:0] a, input logic [7:0] d);
    bus.dn_wr = 1'b1; bus.dn_addr = a; bus.dn_data = d;
    @(negedge clk);
  endtask

  task automatic do_download(input int nbytes);
    @(negedge clk);
    bus.dn_download = 1'b1; bus.dn_wr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < nbytes; i++) begin
      bus.dn_wr   = ($urandom_range(0, 3) != 0);
      bus.dn_data = 8'($urandom);
      if ($urandom_range(0, 7) == 0)      bus.dn_addr = 16'($urandom_range(ROM_SIZE, 65535));
      else if ($urandom_range(0, 1) == 0) bus.dn_addr = 16'($urandom_range(0, 63));
      else                                bus.dn_addr = 16'($urandom_range(0, ROM_SIZE - 1));
      @(negedge clk);
    end
    bus.dn_download = 1'b0;
    @(negedge clk);
    bus.dn_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [15:0] a, input bit abort);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(negedge clk);
    bus.core_rd_req = 1'b1; bus.core_rd_addr = a;
    while (!got && n < (abort ? 6 : 40)) begin
      @(negedge clk);
      n++;
      if (bus.core_rd_ack) got = 1;
      if (abort && n == 2) begin
        bus.dn_download = 1'b1; bus.dn_wr = 1'b0;
      end else if (!abort) begin
        bus.dn_wr = 1'($urandom_range(0, 1)); bus.dn_addr = 16'($urandom); bus.dn_data = 8'($urandom);
      end
    end
    bus.core_rd_req = 1'b0;
    bus.dn_wr = 1'b0;
    if (!abort) begin
      chk("rd_ack_seen", 32'(got), 32'd1);
    end else begin
      @(negedge clk);
      bus.dn_download = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int base;
    int acks;
    int nr;
    chk_en = 1'b0;
    cyc = 0;
    reset_n = 1'b0;
    bus.dn_download = 1'b0; bus.dn_wr = 1'b0; bus.dn_addr = '0; bus.dn_data = '0;
    bus.core_rd_req = 1'b0; bus.core_rd_addr = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // Reset release: core held for HOLD_CYCLES edges, no writes.
    n = 0;
    while (bus.core_reset && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_after_reset", 32'(n), 32'd16);
    chk("no_we_idle", 32'(we_count), 32'd0);

    // Four back-to-back bytes, download falling with the last strobe.
    base = we_count;
    @(negedge clk);
    bus.dn_download = 1'b1;
    @(negedge clk);
    wr_byte(16'h0000, 8'h11);
    wr_byte(16'h0001, 8'h22);
    wr_byte(16'h0002, 8'h33);
    bus.dn_wr = 1'b1; bus.dn_addr = 16'h0003; bus.dn_data = 8'hFF; bus.dn_download = 1'b0;
    chk("load_core_reset", 32'(bus.core_reset), 32'd1);
    @(negedge clk);
    bus.dn_wr = 1'b0;
    repeat (15) @(negedge clk);
    chk("hold_end_minus1", 32'(bus.core_reset), 32'd1);
    @(negedge clk);
    chk("hold_end", 32'(bus.core_reset), 32'd0);
    repeat (2) @(negedge clk);
    chk("four_writes", 32'(we_count - base), 32'd4);
`ifdef ROM_LOAD_CHECKSUM_EN
    chk("checksum_4", 32'(bus.dn_checksum), 32'h0165);
`else
    chk("checksum_4", 32'(bus.dn_checksum), 32'h0000);
`endif

    // Out-of-range write flags dn_err; last in-range address still lands.
    base = we_count;
    bus.dn_download = 1'b1;
    @(negedge clk);
    wr_byte(16'hC000, 8'hAA);
    wr_byte(16'h0123, 8'h5A);
    wr_byte(16'hBFFF, 8'h77);
    bus.dn_wr = 1'b0;
    repeat (3) @(negedge clk);
    chk("dn_err_set", 32'(bus.dn_err), 32'd1);
    chk("oor_dropped", 32'(we_count - base), 32'd2);
`ifdef ROM_LOAD_CHECKSUM_EN
    chk("checksum_2", 32'(bus.dn_checksum), 32'h00D1);
`else
    chk("checksum_2", 32'(bus.dn_checksum), 32'h0000);
`endif
    bus.dn_download = 1'b0;
    repeat (3) @(negedge clk);
    bus.dn_download = 1'b1;
    @(negedge clk);
    chk("dn_err_clear", 32'(bus.dn_err), 32'd0);
    bus.dn_download = 1'b0;
    repeat (20) @(negedge clk);

    // Read latency: address after E1, ack and data after E3.
    bus.core_rd_req = 1'b1; bus.core_rd_addr = 16'h0123;
    @(negedge clk);
    @(negedge clk);
    chk("rd_mem_addr", 32'(bus.mem_addr), 32'h0123);
    @(negedge clk);
    chk("rd_ack_early", 32'(bus.core_rd_ack), 32'd0);
    @(negedge clk);
    chk("rd_ack", 32'(bus.core_rd_ack), 32'd1);
    chk("rd_data_5a", 32'(bus.core_rd_data), 32'h5A);
    bus.core_rd_req = 1'b0;
    @(negedge clk);
    chk("rd_ack_pulse", 32'(bus.core_rd_ack), 32'd0);
    do_read(16'hBFFF, 1'b0);
    chk("rd_data_77", 32'(bus.core_rd_data), 32'h77);

    // Download rising one edge after acceptance aborts the read.
    bus.core_rd_req = 1'b1; bus.core_rd_addr = 16'h0200;
    @(negedge clk);
    bus.dn_download = 1'b1;
    @(negedge clk);
    chk("abort_core_reset", 32'(bus.core_reset), 32'd1);
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.core_rd_ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    bus.core_rd_req = 1'b0;
    bus.dn_download = 1'b0;
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of a load.
    bus.dn_download = 1'b1;
    @(negedge clk);
    wr_byte(16'hC100, 8'h01);
    wr_byte(16'h0005, 8'h40);
    bus.dn_wr = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_core_reset", 32'(bus.core_reset), 32'd1);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_dn_err", 32'(bus.dn_err), 32'd0);
    chk("rst_checksum", 32'(bus.dn_checksum), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    bus.dn_download = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (bus.core_reset && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("hold_after_rst2", 32'(n), 32'd16);

    // Randomized traffic against the model.
    for (int it = 0; it < 25; it++) begin
      do_download($urandom_range(4, 40));
      repeat ($urandom_range(0, 20)) @(negedge clk);
      nr = $urandom_range(2, 6);
      for (int r = 0; r < nr; r++) begin
        if ($urandom_range(0, 1) == 0) do_read(16'($urandom_range(0, 63)), ($urandom_range(0, 7) == 0));
        else                           do_read(16'($urandom), ($urandom_range(0, 7) == 0));
      end
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
